bp_fpga_host_nbf_tx_sched: RTL and testbench

BP_FPGA_HOST_NBF_TX_SCHED -- requirements
Module: bp_fpga_host_nbf_tx_sched

---
 rtl/bp_fpga_host_nbf_tx_sched_pkg.sv | 47 ++++
 rtl/bp_fpga_host_nbf_tx_sched_arb.sv | 71 +++++++
 rtl/bp_fpga_host_nbf_tx_sched.sv | 102 ++++++++++
 tb/tb_bp_fpga_host_nbf_tx_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bp_fpga_host_nbf_tx_sched_pkg.sv
// Shared types for the FPGA-host NBF transmit scheduler: configuration
// selector, NBF opcodes and field-width helpers.
package bp_fpga_host_nbf_tx_sched_pkg;

   // Processor configurations the host can be built against
   typedef enum logic [1:0] {
      e_bp_default_cfg     = 2'd0,
      e_bp_dual_core_cfg   = 2'd1,
      e_bp_quad_core_cfg   = 2'd2
   } bp_params_e;

   localparam int dword_width_gp      = 64;
   localparam int nbf_opcode_width_gp = 8;

   // NBF opcodes seen on the host transmit path
   typedef enum logic [nbf_opcode_width_gp-1:0] {
      e_fpga_host_nbf_write     = 8'h03,
      e_fpga_host_nbf_read      = 8'h13,
      e_fpga_host_nbf_core_done = 8'h80,
      e_fpga_host_nbf_putch     = 8'h81,
      e_fpga_host_nbf_fence     = 8'hFE,
      e_fpga_host_nbf_finish    = 8'hFF
   } bp_fpga_host_nbf_opcode_e;

   // Physical address width of a configuration
   function automatic int bp_paddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_quad_core_cfg: return 40;
         default:            return 40;
      endcase
   endfunction

   // Core count of a configuration
   function automatic int bp_num_core(bp_params_e cfg);
      case (cfg)
         e_bp_dual_core_cfg: return 2;
         e_bp_quad_core_cfg: return 4;
         default:            return 1;
      endcase
   endfunction

   // Packed NBF layout is {opcode, addr, data}, opcode in the MSBs
   function automatic int nbf_width(int addr_width, int data_width);
      return nbf_opcode_width_gp + addr_width + data_width;
   endfunction

endpackage

// File: rtl/bp_fpga_host_nbf_tx_sched_arb.sv
// Two-source priority arbiter with a starvation counter: the high-priority
// source wins until it has been granted starve_limit_p times in a row while
// the low source was waiting, then the low source gets one forced grant.
module bp_fpga_host_nbf_tx_sched_arb
   #(parameter int starve_limit_p = 4
   , localparam int cnt_width_lp = $clog2(starve_limit_p + 1)
   )
   (input  logic clk_i
   , input  logic reset_n_i
   , input  logic load_en_i
   , input  logic hi_v_i
   , input  logic lo_v_i
   , output logic hi_ready_and_o
   , output logic lo_ready_and_o
   );

   typedef enum logic {e_hi_pri, e_lo_forced} state_e;

   localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

   state_e                  state_r;
   logic [cnt_width_lp-1:0] starve_cnt_r;
   logic [cnt_width_lp-1:0] starve_cnt_next;
   logic                    hi_hs, lo_hs;

   // Readies depend only on state, load_en and the other port's valid
   assign hi_ready_and_o = reset_n_i & load_en_i & (state_r == e_hi_pri);
   assign lo_ready_and_o = reset_n_i & load_en_i & ((state_r == e_lo_forced) | ~hi_v_i);

   assign hi_hs = hi_v_i & hi_ready_and_o;
   assign lo_hs = lo_v_i & lo_ready_and_o;

   // Next starvation count: cleared by a low grant, bumped by a high grant that made low wait
   always_comb begin
      // NOTE: default first so every path assigns the variable and no latch is inferred
      starve_cnt_next = starve_cnt_r;
      if (lo_hs)
         starve_cnt_next = '0;
      else if (hi_hs & lo_v_i)
         starve_cnt_next = starve_cnt_r + 1'b1;
   end

   // Arbitration state and starvation counter
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values
         state_r      <= e_hi_pri;
         starve_cnt_r <= '0;
      end else begin
         case (state_r)
            e_hi_pri: begin
               starve_cnt_r <= starve_cnt_next;
               if (starve_cnt_next == limit_lp)
                  state_r <= e_lo_forced;
            end
            e_lo_forced: begin
               // Leave on the forced grant, or if the low source withdrew
               if (lo_hs | ~lo_v_i) begin
                  state_r      <= e_hi_pri;
                  starve_cnt_r <= '0;
               end
            end
            default: begin
               state_r      <= e_hi_pri;
               starve_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bp_fpga_host_nbf_tx_sched.sv
// Merges host IO-in responses (high priority) and IO-cmd FSM packets (low
// priority) into one NBF stream toward the UART transmitter, and tracks
// which cores have reported core_done.
module bp_fpga_host_nbf_tx_sched
   import bp_fpga_host_nbf_tx_sched_pkg::*;
   #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   , parameter int nbf_addr_width_p = bp_paddr_width(bp_params_p)
   , parameter int nbf_data_width_p = dword_width_gp
   , parameter int starve_limit_p   = 4
   , localparam int num_core_p      = bp_num_core(bp_params_p)
   , localparam int nbf_width_lp    = nbf_width(nbf_addr_width_p, nbf_data_width_p)
   )
   (input  logic                    clk_i
   , input  logic                    reset_n_i
   , input  logic [nbf_width_lp-1:0] hi_nbf_i
   , input  logic                    hi_v_i
   , output logic                    hi_ready_and_o
   , input  logic [nbf_width_lp-1:0] lo_nbf_i
   , input  logic                    lo_v_i
   , output logic                    lo_ready_and_o
   , output logic [nbf_width_lp-1:0] nbf_o
   , output logic                    nbf_v_o
   , input  logic                    nbf_ready_and_i
   , output logic                    all_done_o
   );

   logic [nbf_width_lp-1:0]        nbf_r;
   logic                           v_r;
   logic                           load_en;
   logic                           hi_hs, lo_hs, accept;
   logic [nbf_width_lp-1:0]        sel_nbf;
   logic [nbf_opcode_width_gp-1:0] sel_opcode;
   logic [nbf_addr_width_p-1:0]    sel_addr;
   logic [num_core_p-1:0]          done_mask_r;
   logic [num_core_p-1:0]          done_set;
   logic [num_core_p-1:0]          done_mask_next;
   logic                           all_done_r;

   // The output register can take a new packet when empty or draining
   assign load_en = ~v_r | nbf_ready_and_i;

   bp_fpga_host_nbf_tx_sched_arb
      #(.starve_limit_p(starve_limit_p))
      arb
      (.clk_i          (clk_i)
      ,.reset_n_i      (reset_n_i)
      ,.load_en_i      (load_en)
      ,.hi_v_i         (hi_v_i)
      ,.lo_v_i         (lo_v_i)
      ,.hi_ready_and_o (hi_ready_and_o)
      ,.lo_ready_and_o (lo_ready_and_o)
      );

   assign hi_hs  = hi_v_i & hi_ready_and_o;
   assign lo_hs  = lo_v_i & lo_ready_and_o;
   assign accept = hi_hs | lo_hs;

   assign sel_nbf    = hi_hs ? hi_nbf_i : lo_nbf_i;
   assign sel_opcode = sel_nbf[nbf_width_lp-1 -: nbf_opcode_width_gp];
   assign sel_addr   = sel_nbf[nbf_data_width_p +: nbf_addr_width_p];

   // Decode an accepted core_done into its core bit; out-of-range addresses match no bit
   always_comb begin
      done_set = '0;
      if (accept && (sel_opcode == e_fpga_host_nbf_core_done)) begin
         for (int i = 0; i < num_core_p; i++) begin
            if (sel_addr == nbf_addr_width_p'(i))
               done_set[i] = 1'b1;
         end
      end
   end

   assign done_mask_next = done_mask_r | done_set;

   // Output register: loads the granted packet, holds it under backpressure
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_r   <= 1'b0;
         nbf_r <= '0;
      end else if (load_en) begin
         v_r <= accept;
         if (accept)
            nbf_r <= sel_nbf;
      end
   end

   // Core completion tracking; all_done is sticky and rises with the last core_done's output cycle
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         done_mask_r <= '0;
         all_done_r  <= 1'b0;
      end else begin
         done_mask_r <= done_mask_next;
         all_done_r  <= all_done_r | (&done_mask_next);
      end
   end

   assign nbf_o      = nbf_r;
   assign nbf_v_o    = v_r;
   assign all_done_o = all_done_r;

endmodule

// File: tb/tb_bp_fpga_host_nbf_tx_sched.sv
// Directed bench for the NBF transmit scheduler: single lo packet, starvation
// ordering, lo withdrawal, backpressure, core_done tracking, async reset.
module tb_bp_fpga_host_nbf_tx_sched;
   import bp_fpga_host_nbf_tx_sched_pkg::*;

   localparam int aw_lp = 8;
   localparam int dw_lp = 16;
   localparam int w_lp  = 8 + aw_lp + dw_lp;

   logic            clk;
   logic            reset_n;
   logic [w_lp-1:0] hi_nbf, lo_nbf, nbf;
   logic            hi_v, lo_v, hi_ready, lo_ready, nbf_v, nbf_ready, all_done;

   int tests = 0;
   int fails = 0;

   bp_fpga_host_nbf_tx_sched
      #(.bp_params_p(e_bp_dual_core_cfg)
      ,.nbf_addr_width_p(aw_lp)
      ,.nbf_data_width_p(dw_lp)
      ,.starve_limit_p(4))
      dut
      (.clk_i           (clk)
      ,.reset_n_i       (reset_n)
      ,.hi_nbf_i        (hi_nbf)
      ,.hi_v_i          (hi_v)
      ,.hi_ready_and_o  (hi_ready)
      ,.lo_nbf_i        (lo_nbf)
      ,.lo_v_i          (lo_v)
      ,.lo_ready_and_o  (lo_ready)
      ,.nbf_o           (nbf)
      ,.nbf_v_o         (nbf_v)
      ,.nbf_ready_and_i (nbf_ready)
      ,.all_done_o      (all_done)
      );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [w_lp-1:0] obs, input logic [w_lp-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [w_lp-1:0] mk(input logic [7:0] op, input logic [7:0] a, input logic [15:0] d);
      return {op, a, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [w_lp-1:0] pkt_h, pkt_l, pkt_h2, pkt_h3;
   logic [w_lp-1:0] done_pkts [4];
   string           pat;

   initial begin
      pkt_h  = mk(e_fpga_host_nbf_read,  8'h10, 16'hAAAA);
      pkt_l  = mk(e_fpga_host_nbf_putch, 8'h00, 16'h0042);
      pkt_h2 = mk(e_fpga_host_nbf_write, 8'h22, 16'h1234);
      pkt_h3 = mk(e_fpga_host_nbf_write, 8'h33, 16'h5678);
      done_pkts[0] = mk(e_fpga_host_nbf_core_done, 8'd0, 16'h0001);
      done_pkts[1] = mk(e_fpga_host_nbf_core_done, 8'd0, 16'h0002);
      done_pkts[2] = mk(e_fpga_host_nbf_core_done, 8'd5, 16'h0003);
      done_pkts[3] = mk(e_fpga_host_nbf_core_done, 8'd1, 16'h0004);

      // Reset state
      reset_n = 1'b0; hi_v = 1'b0; lo_v = 1'b0; nbf_ready = 1'b1;
      hi_nbf = '0; lo_nbf = '0;
      #2;
      check("rst_nbf_v", nbf_v, 0);
      check("rst_all_done", all_done, 0);
      check("rst_hi_ready", hi_ready, 0);
      check("rst_lo_ready", lo_ready, 0);
      #10 reset_n = 1'b1;
      tick();
      check("idle_hi_ready", hi_ready, 1);
      check("idle_lo_ready", lo_ready, 1);
      check("idle_nbf_v", nbf_v, 0);

      // Single lo putch with latency 1
      lo_nbf = mk(e_fpga_host_nbf_putch, 8'h00, 16'h0041); lo_v = 1'b1;
      #1 check("putch_lo_ready", lo_ready, 1);
      tick();
      check("putch_v", nbf_v, 1);
      check("putch_data", nbf, mk(e_fpga_host_nbf_putch, 8'h00, 16'h0041));
      lo_v = 1'b0;
      tick();
      check("putch_drain_v", nbf_v, 0);

      // Both sources held: hi x4 then one forced lo, repeating
      hi_nbf = pkt_h; hi_v = 1'b1; lo_nbf = pkt_l; lo_v = 1'b1;
      #1;
      check("starve_hi_ready0", hi_ready, 1);
      check("starve_lo_ready0", lo_ready, 0);
      pat = "HHHHLHHHHL";
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("starve_grant%0d", k), nbf, (pat[k] == "L") ? pkt_l : pkt_h);
         check($sformatf("starve_v%0d", k), nbf_v, 1);
         if (k == 3) begin
            check("forced_hi_ready", hi_ready, 0);
            check("forced_lo_ready", lo_ready, 1);
         end
      end
      hi_v = 1'b0; lo_v = 1'b0;
      tick();
      check("starve_idle_v", nbf_v, 0);

      // Lo withdraws while forced: back to hi priority with count cleared
      hi_v = 1'b1; lo_v = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("wd_last_hi", nbf, pkt_h);
      lo_v = 1'b0;
      #1;
      check("wd_forced_hi_ready", hi_ready, 0);
      tick();
      check("wd_bubble_v", nbf_v, 0);
      check("wd_back_hi_ready", hi_ready, 1);
      lo_v = 1'b1;
      pat = "HHHHL";
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("wd_grant%0d", k), nbf, (pat[k] == "L") ? pkt_l : pkt_h);
      end
      hi_v = 1'b0; lo_v = 1'b0;
      tick();

      // Backpressure holds the output register and blocks both sources
      hi_nbf = pkt_h2; hi_v = 1'b1;
      tick();
      check("bp_load", nbf, pkt_h2);
      nbf_ready = 1'b0; hi_nbf = pkt_h3; lo_v = 1'b1;
      #1;
      check("bp_hi_ready", hi_ready, 0);
      check("bp_lo_ready", lo_ready, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("bp_hold%0d", k), nbf, pkt_h2);
         check($sformatf("bp_hold_v%0d", k), nbf_v, 1);
         check($sformatf("bp_hold_rdy%0d", k), {hi_ready, lo_ready}, 0);
      end
      nbf_ready = 1'b1;
      #1 check("bp_release_hi_ready", hi_ready, 1);
      tick();
      check("bp_next", nbf, pkt_h3);
      hi_v = 1'b0; lo_v = 1'b0;
      tick();

      // core_done tracking with duplicate and out-of-range address
      for (int k = 0; k < 4; k++) begin
         lo_nbf = done_pkts[k]; lo_v = 1'b1;
         tick();
         check($sformatf("done_fwd%0d", k), nbf, done_pkts[k]);
         check($sformatf("done_v%0d", k), nbf_v, 1);
         check($sformatf("all_done%0d", k), all_done, (k == 3) ? 1 : 0);
      end
      lo_v = 1'b0;
      tick();
      check("all_done_sticky", all_done, 1);

      // Async reset mid-stream while forced and holding a packet
      hi_nbf = pkt_h; hi_v = 1'b1; lo_nbf = pkt_l; lo_v = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("pre_rst_v", nbf_v, 1);
      check("pre_rst_forced", hi_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_v", nbf_v, 0);
      check("mid_rst_nbf", nbf, 0);
      check("mid_rst_all_done", all_done, 0);
      check("mid_rst_rdy", {hi_ready, lo_ready}, 0);
      #3 reset_n = 1'b1;
      #1;
      check("post_rst_hi_ready", hi_ready, 1);
      check("post_rst_lo_ready", lo_ready, 0);
      tick();
      check("post_rst_grant", nbf, pkt_h);
      check("post_rst_all_done", all_done, 0);
      hi_v = 1'b0; lo_v = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
